// File: rtl/sap1_controller_if.sv
// Control bundle between the SAP-1 sequencer and its datapath.
// Handshake: none; run gates sequencing, every control line is a level valid for the current cycle.
interface sap1_controller_if;
    logic       run;
    logic [3:0] opcode;
    logic       pc_inc;
    logic       pc_en;
    logic       mar_load;
    logic       ram_en;
    logic       ir_load;
    logic       ir_en;
    logic       a_load;
    logic       a_en;
    logic       alu_sub;
    logic       alu_en;
    logic       b_load;
    logic       out_load;
    logic [5:0] t_state;
    logic       halted;

    modport master (
        input  run, opcode,
        output pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
               a_load, a_en, alu_sub, alu_en, b_load, out_load,
               t_state, halted
    );

    modport slave (
        output run, opcode,
        input  pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
               a_load, a_en, alu_sub, alu_en, b_load, out_load,
               t_state, halted
    );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: one-hot T-state ring plus opcode decode into the
// per-cycle control word; owns halt and run gating.
module sap1_controller #(
    parameter logic [3:0] OP_LDA    = 4'h0,
    parameter logic [3:0] OP_ADD    = 4'h1,
    parameter logic [3:0] OP_SUB    = 4'h2,
    parameter logic [3:0] OP_OUT    = 4'hE,
    parameter logic [3:0] OP_HLT    = 4'hF,
    parameter bit         EARLY_END = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sap1_controller_if.master bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state_q, state_d;
    logic     halted_q, halted_d;

    logic pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
    logic a_load, a_en, alu_sub, alu_en, b_load, out_load;

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

    assign is_lda = (bus.opcode == OP_LDA);
    assign is_add = (bus.opcode == OP_ADD);
    assign is_sub = (bus.opcode == OP_SUB);
    assign is_out = (bus.opcode == OP_OUT);
    assign is_hlt = (bus.opcode == OP_HLT);
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Only one bus driver is ever selected because each T-state decodes at most one source.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        pc_inc   = 1'b0;
        pc_en    = 1'b0;
        mar_load = 1'b0;
        ram_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        a_load   = 1'b0;
        a_en     = 1'b0;
        alu_sub  = 1'b0;
        alu_en   = 1'b0;
        b_load   = 1'b0;
        out_load = 1'b0;
        if (rst && bus.run && !halted_q) begin
            case (state_q)
                T1: begin
                    pc_en    = 1'b1;
                    mar_load = 1'b1;
                    state_d  = T2;
                end
                T2: begin
                    pc_inc  = 1'b1;
                    state_d = T3;
                end
                T3: begin
                    ram_en  = 1'b1;
                    ir_load = 1'b1;
                    state_d = T4;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        ir_en    = 1'b1;
                        mar_load = 1'b1;
                    end else if (is_out) begin
                        a_en     = 1'b1;
                        out_load = 1'b1;
                    end
                    // HLT parks the ring in T4 for good; only reset leaves it.
                    if (is_hlt)
                        halted_d = 1'b1;
                    else if (EARLY_END && (is_out || is_nop))
                        state_d = T1;
                    else
                        state_d = T5;
                end
                T5: begin
                    if (is_lda) begin
                        ram_en = 1'b1;
                        a_load = 1'b1;
                    end else if (is_add || is_sub) begin
                        ram_en = 1'b1;
                        b_load = 1'b1;
                    end
                    state_d = (EARLY_END && is_lda) ? T1 : T6;
                end
                T6: begin
                    if (is_add || is_sub) begin
                        alu_en  = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = is_sub;
                    end
                    state_d = T1;
                end
                default: state_d = T1;
            endcase
        end
    end

    assign bus.pc_inc   = pc_inc;
    assign bus.pc_en    = pc_en;
    assign bus.mar_load = mar_load;
    assign bus.ram_en   = ram_en;
    assign bus.ir_load  = ir_load;
    assign bus.ir_en    = ir_en;
    assign bus.a_load   = a_load;
    assign bus.a_en     = a_en;
    assign bus.alu_sub  = alu_sub;
    assign bus.alu_en   = alu_en;
    assign bus.b_load   = b_load;
    assign bus.out_load = out_load;
    assign bus.t_state  = state_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: two instances (EARLY_END 0 and 1) run side by side
// against an instruction-step reference model.
`timescale 1ns/1ps
module tb_sap1_controller;

    localparam int PC_INC = 11, PC_EN = 10, MAR_LOAD = 9, RAM_EN = 8;
    localparam int IR_LOAD = 7, IR_EN = 6, A_LOAD = 5, A_EN = 4;
    localparam int ALU_SUB = 3, ALU_EN = 2, B_LOAD = 1, OUT_LOAD = 0;

    logic clk;
    logic rst;
    logic run;
    logic [3:0] opcode;

    int n_checks = 0;
    int n_fail   = 0;

    // model: instruction step 1..6 and halted flag, per instance (0: EARLY_END=0, 1: EARLY_END=1)
    int st[2];
    bit hl[2];
    logic [5:0] exp_q[$];

    sap1_controller_if b0 ();
    sap1_controller_if b1 ();

    assign b0.run = run;
    assign b0.opcode = opcode;
    assign b1.run = run;
    assign b1.opcode = opcode;

    sap1_controller #(.EARLY_END(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    sap1_controller #(.EARLY_END(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic [11:0] cw0, cw1;
    assign cw0 = {b0.pc_inc, b0.pc_en, b0.mar_load, b0.ram_en, b0.ir_load, b0.ir_en,
                  b0.a_load, b0.a_en, b0.alu_sub, b0.alu_en, b0.b_load, b0.out_load};
    assign cw1 = {b1.pc_inc, b1.pc_en, b1.mar_load, b1.ram_en, b1.ir_load, b1.ir_en,
                  b1.a_load, b1.a_en, b1.alu_sub, b1.alu_en, b1.b_load, b1.out_load};

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] exp_word(input int step, input logic [3:0] op,
                                             input logic r, input bit h, input logic rs);
        logic [11:0] w;
        w = '0;
        if (rs && r && !h) begin
            case (step)
                1: begin w[PC_EN] = 1'b1; w[MAR_LOAD] = 1'b1; end
                2: w[PC_INC] = 1'b1;
                3: begin w[RAM_EN] = 1'b1; w[IR_LOAD] = 1'b1; end
                4: if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                       w[IR_EN] = 1'b1; w[MAR_LOAD] = 1'b1;
                   end else if (op == 4'hE) begin
                       w[A_EN] = 1'b1; w[OUT_LOAD] = 1'b1;
                   end
                5: if (op == 4'h0) begin
                       w[RAM_EN] = 1'b1; w[A_LOAD] = 1'b1;
                   end else if (op == 4'h1 || op == 4'h2) begin
                       w[RAM_EN] = 1'b1; w[B_LOAD] = 1'b1;
                   end
                6: if (op == 4'h1 || op == 4'h2) begin
                       w[ALU_EN] = 1'b1; w[A_LOAD] = 1'b1; w[ALU_SUB] = (op == 4'h2);
                   end
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    // number of T-states an instruction occupies
    function automatic int instr_len(input logic [3:0] op, input bit early);
        if (!early || op == 4'h1 || op == 4'h2) return 6;
        if (op == 4'h0) return 5;
        return 4;
    endfunction

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (rst && run && !hl[k]) begin
                if (st[k] == 4 && opcode == 4'hF) hl[k] = 1'b1;
                else if (st[k] == instr_len(opcode, k == 1) || st[k] == 6) st[k] = 1;
                else st[k] = st[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [5:0]  ts;
        logic [11:0] cw;
        logic        h;
        int          drv;
        for (int k = 0; k < 2; k++) begin
            ts = (k == 0) ? b0.t_state : b1.t_state;
            cw = (k == 0) ? cw0 : cw1;
            h  = (k == 0) ? b0.halted : b1.halted;
            chk($sformatf("t_state[ee%0d]", k), 12'(ts), 12'(6'b1 << (st[k] - 1)));
            chk($sformatf("halted[ee%0d]", k), 12'(h), 12'(hl[k]));
            chk($sformatf("ctrl[ee%0d]", k), cw, exp_word(st[k], opcode, run, hl[k], rst));
            chk($sformatf("onehot[ee%0d]", k), 12'($onehot(ts)), 12'd1);
            drv = int'(cw[PC_EN]) + int'(cw[RAM_EN]) + int'(cw[IR_EN]) + int'(cw[A_EN]) + int'(cw[ALU_EN]);
            chk($sformatf("one_driver[ee%0d]", k), 12'(drv <= 1), 12'd1);
            chk($sformatf("sub_gate[ee%0d]", k), 12'(cw[ALU_SUB] & ~cw[ALU_EN]), 12'd0);
        end
    endtask

    // driver: apply inputs at the falling edge, check, then let one rising edge pass
    task automatic do_cycle(input logic r, input logic [3:0] op);
        run = r;
        opcode = op;
        #1;
        check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        st[0] = 1; st[1] = 1; hl[0] = 1'b0; hl[1] = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    task automatic chk_seq(input int k);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            chk("seq_underflow", 12'd1, 12'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("seq[ee%0d]", k), 12'((k == 0) ? b0.t_state : b1.t_state), 12'(e));
        end
    endtask

    logic [3:0] rop;

    initial begin
        rst = 1'b0;
        run = 1'b0;
        opcode = 4'h0;
        @(negedge clk);
        do_reset();

        // LDA: ring walks all six states and wraps
        exp_q = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        for (int i = 0; i < 6; i++) begin
            run = 1'b1; opcode = 4'h0; #1; chk_seq(0);
            @(negedge clk);
            st[0] = st[0]; // model advanced below via do_cycle path instead
        end
        #1; chk_seq(0);
        do_reset();
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 4'h0);
        do_reset();

        // SUB then ADD, full-length in both instances
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 4'h2);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 4'h1);
        #1; chk("add_wrap", 12'(b0.t_state), 12'h001);

        // HLT: park in T4 for 20 cycles, then reset releases it
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 4'hF);
        for (int i = 0; i < 20; i++) do_cycle(($urandom_range(0, 1) == 1), 4'($urandom));
        #1; chk("halt_ts", 12'(b0.t_state), 12'h008);
        chk("halt_flag", 12'(b1.halted), 12'h001);
        do_reset();
        #1; chk("halt_release", 12'(b0.halted), 12'h000);

        // EARLY_END lengths: OUT 4, NOP 4, LDA 5
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 4'hE);
        #1; chk("ee_out_len", 12'(b1.t_state), 12'h001);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 4'h7);
        #1; chk("ee_nop_len", 12'(b1.t_state), 12'h001);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 4'h0);
        #1; chk("ee_lda_len", 12'(b1.t_state), 12'h001);
        do_reset();

        // ADD with run dropped in T5 for three cycles
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 4'h1);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 4'h1);
        #1; chk("run_hold", 12'(b0.t_state), 12'h010);
        do_cycle(1'b1, 4'h1);
        #1; chk("run_resume", 12'(b0.t_state), 12'h020);

        // asynchronous reset mid-T6 of an ADD, between clock edges
        do_reset();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 4'h1);
        #1;
        chk("pre_async_t6", 12'(b0.t_state), 12'h020);
        #2;
        rst = 1'b0;
        st[0] = 1; st[1] = 1; hl[0] = 1'b0; hl[1] = 1'b0;
        #1;
        check_all();
        chk("async_ctrl", cw0 | cw1, 12'h000);
        @(negedge clk);
        rst = 1'b1;

        // random soak: HLT kept rare, reset used to leave halt
        for (int i = 0; i < 10000; i++) begin
            rop = 4'($urandom);
            if (rop == 4'hF && $urandom_range(0, 7) != 0) rop = 4'h0;
            if ((hl[0] || hl[1]) && $urandom_range(0, 5) == 0) do_reset();
            else do_cycle(($urandom_range(0, 9) != 0), rop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
Control sequencer for the SAP-1 datapath. It runs a one-hot T-state ring counter and decodes the instruction-register opcode into the per-cycle control word. That control word drives the program counter, MAR, RAM, IR, accumulator A, ALU, B register and output register. It also owns the halt state, the run gating and a bus-driver exclusivity guarantee.

Parameters:
OP_LDA, 4'h0, opcode for load A from memory
OP_ADD, 4'h1, opcode for A = A + mem
OP_SUB, 4'h2, opcode for A = A - mem
OP_OUT, 4'hE, opcode for output register = A
OP_HLT, 4'hF, opcode for halt
EARLY_END, 0, when 1, return to T1 right after the last T-state that has an active control for the opcode

Ports:
clk        input   1  system clock; all state changes on the rising edge
rst        input   1  asynchronous reset, active-low (0 = reset)
run        input   1  run enable; when 0 the sequencer freezes
opcode     input   4  upper nibble of the instruction register
pc_inc     output  1  Cp: increment program counter
pc_en      output  1  Ep: PC drives bus
mar_load   output  1  Lm: MAR loads from bus
ram_en     output  1  CE: RAM drives bus
ir_load    output  1  Li: IR loads from bus
ir_en      output  1  Ei: IR operand nibble drives bus
a_load     output  1  La: accumulator loads from bus
a_en       output  1  Ea: accumulator drives bus
alu_sub    output  1  Su: ALU subtract select
alu_en     output  1  Eu: ALU drives bus
b_load     output  1  Lb: B register loads from bus
out_load   output  1  Lo: output register loads from bus
t_state    output  6  one-hot current T-state; bit0 = T1
halted     output  1  high once HLT has executed

Behaviour:
- State: t_state (one-hot) plus a halted flag. The control word is decoded combinationally from t_state, opcode, run, halted and rst. No control output is registered.
- Reset (rst=0, asynchronous): t_state=6'b000001, halted=0. Every control output is forced to 0 while rst=0.
- Advance: on each rising edge with run=1 and halted=0, T1→T2→…→T6→T1.
- run=0: t_state and halted hold, and all control outputs are 0. When run returns to 1, the same T-state re-issues its full control word.
- Fetch control word, identical for all opcodes:
  - T1: pc_en, mar_load
  - T2: pc_inc
  - T3: ram_en, ir_load
- Execute control word:
  - LDA: T4 ir_en, mar_load; T5 ram_en, a_load; T6 none.
  - ADD: T4 ir_en, mar_load; T5 ram_en, b_load; T6 alu_en, a_load.
  - SUB: same as ADD, plus alu_sub in T6.
  - OUT: T4 a_en, out_load; T5 and T6 none.
  - HLT: T4 none; the T4 edge sets halted=1 and the ring does not advance.
  - Any other opcode is a NOP: T4–T6 none.
- Opcode is sampled only in T4–T6; its value in T1–T3 is don't-care.
- Halted: t_state stays at T4, all control outputs are 0, halted=1 until reset. run has no effect while halted.
- EARLY_END=1: the ring goes to T1 instead of T5 after T4 for OUT and NOP, and instead of T6 after T5 for LDA. ADD and SUB always use all six states. HLT behaviour is unchanged.
- Invariants, required at all times:
  - t_state is exactly one-hot.
  - At most one of pc_en, ram_en, ir_en, a_en, alu_en is 1.
  - alu_sub=1 only when alu_en=1.
- If rst is asserted mid-instruction, everything returns to T1 immediately and the partial instruction is abandoned.

Test Plan:
- Reset, then run=1 with opcode=0x0 (LDA): t_state sequence 01,02,04,08,10,20,01. Control words: T1 {pc_en,mar_load}; T2 {pc_inc}; T3 {ram_en,ir_load}; T4 {ir_en,mar_load}; T5 {ram_en,a_load}; T6 all 0.
- opcode=0x2 (SUB), EARLY_END=0: T5 {ram_en,b_load}; T6 {alu_en,a_load,alu_sub}; next state T1. Repeat with opcode=0x1: alu_sub=0 in T6.
- opcode=0xF: T4 word all 0. After that edge halted=1 and t_state=08 for 20 cycles with all controls 0. Pulse rst low: t_state=01, halted=0.
- opcode=0xE with EARLY_END=1: T4 {a_en,out_load}, then next state is T1 (instruction length 4 cycles). Opcode=0x7 also returns to T1 after T4. Opcode=0x0 returns to T1 after T5.
- Drop run in T5 of an ADD for 3 cycles: t_state holds at 10 with controls 0. When run returns, T5 re-issues {ram_en,b_load}, then T6 follows.
- Assert rst asynchronously mid-T6 of an ADD, between clock edges: controls drop to 0 immediately and t_state=01 without waiting for a clock edge. Random opcode/run soak of 10k cycles: one-hot and single-bus-driver assertions never fail.
